// File: rtl/pe_tile_param_pkg.sv
// Shared encodings for every pe_tile_param variant: sub-unit codes,
// switch-box select values and CLB opcodes.
package pe_tile_param_pkg;

  localparam logic [15:0] UNIT_SB  = 16'd7;
  localparam logic [15:0] UNIT_CB0 = 16'd6;
  localparam logic [15:0] UNIT_CB1 = 16'd5;
  localparam logic [15:0] UNIT_CLB = 16'd4;

  typedef enum logic [2:0] {
    SB_ZERO  = 3'd0,
    SB_SIDE0 = 3'd1,
    SB_SIDE1 = 3'd2,
    SB_SIDE2 = 3'd3,
    SB_SIDE3 = 3'd4,
    SB_PE    = 3'd5
  } sb_sel_e;

  typedef enum logic [1:0] {
    CLB_AND = 2'd0,
    CLB_OR  = 2'd1,
    CLB_XOR = 2'd2,
    CLB_NOT = 2'd3
  } clb_op_e;

  function automatic logic clb_eval(input clb_op_e op, input logic in0, input logic in1);
    case (op)
      CLB_AND: clb_eval = in0 & in1;
      CLB_OR:  clb_eval = in0 | in1;
      CLB_XOR: clb_eval = in0 ^ in1;
      default: clb_eval = ~in0;
    endcase
  endfunction

endpackage

// File: rtl/connect_box_param.sv
// Connect box: one select register choosing among a side's track inputs
// (sel < NUM_TRACKS) or that side's track outputs (sel >= NUM_TRACKS).
module connect_box_param
  import pe_tile_param_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int CB_SEL_W   = $clog2(2 * NUM_TRACKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [CB_SEL_W-1:0]   wsel,
  input  logic [NUM_TRACKS-1:0] in_side,
  input  logic [NUM_TRACKS-1:0] out_side,
  output logic                  cb_out
);

  logic [CB_SEL_W-1:0] sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_q <= '0;
    else if (we) sel_q <= wsel;
  end

  always_comb begin
    cb_out = 1'b0;
    for (int i = 0; i < NUM_TRACKS; i++) begin
      if (sel_q == CB_SEL_W'(i)) cb_out = in_side[i];
      if (sel_q == CB_SEL_W'(i + NUM_TRACKS)) cb_out = out_side[i];
    end
  end

endmodule

// File: rtl/pe_tile_param.sv
// Routing tile: switch box, two connect boxes feeding a 1-bit PE, and a
// memory-mapped configuration port with ack/err pulses.
module pe_tile_param
  import pe_tile_param_pkg::*;
#(
  parameter int NUM_TRACKS    = 4,
  parameter bit HAS_SIDE0_OUT = 1'b1,
  parameter int CB_SEL_W      = $clog2(2 * NUM_TRACKS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             config_addr,
  input  logic [31:0]             config_data,
  input  logic                    config_valid,
  input  logic [15:0]             tile_id,
  input  logic [4*NUM_TRACKS-1:0] in_wire,
  output logic [4*NUM_TRACKS-1:0] out_wire,
  output logic                    config_ack,
  output logic                    config_err,
  output logic                    pe_out
);

  localparam int NW = 4 * NUM_TRACKS;

  logic          hit;
  logic [15:0]   unit;
  logic [7:0]    sb_o;
  logic [2:0]    sb_s;
  logic          sb_bad, cb_bad, wr_bad;
  logic          sb_wr, cb0_wr, cb1_wr, clb_wr;
  logic [NW-1:0] sb_we;
  logic [2:0]    sb_sel [NW];
  clb_op_e       clb_op;
  logic          clb_reg_en;
  logic          cb0_out, cb1_out;
  logic          pe_comb, pe_p1;
  logic          unused_cfg;

  assign hit        = config_valid && (config_addr[15:0] == tile_id);
  assign unit       = config_addr[31:16];
  assign sb_o       = config_data[7:0];
  assign sb_s       = config_data[10:8];
  assign cb_bad     = int'(config_data[CB_SEL_W-1:0]) >= 2 * NUM_TRACKS;
  assign unused_cfg = ^config_data[31:11];

  always_comb begin
    sb_bad = 1'b0;
    if (int'(sb_o) >= NW) sb_bad = 1'b1;
    if (sb_s > SB_PE) sb_bad = 1'b1;
    // A track may not be driven back out of the side it arrived on.
    if (sb_s >= SB_SIDE0 && sb_s <= SB_SIDE3 && int'(sb_s) - 1 == int'(sb_o) / NUM_TRACKS)
      sb_bad = 1'b1;
    if (!HAS_SIDE0_OUT && int'(sb_o) < NUM_TRACKS) sb_bad = 1'b1;
  end

  always_comb begin
    sb_wr  = 1'b0;
    cb0_wr = 1'b0;
    cb1_wr = 1'b0;
    clb_wr = 1'b0;
    wr_bad = 1'b0;
    if (hit) begin
      case (unit)
        UNIT_SB:  if (sb_bad) wr_bad = 1'b1; else sb_wr  = 1'b1;
        UNIT_CB0: if (cb_bad) wr_bad = 1'b1; else cb0_wr = 1'b1;
        UNIT_CB1: if (cb_bad) wr_bad = 1'b1; else cb1_wr = 1'b1;
        UNIT_CLB: clb_wr = 1'b1;
        default:  wr_bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NW; i++) sb_we[i] = sb_wr && (int'(sb_o) == i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) sb_sel[i] <= SB_ZERO;
    end else begin
      for (int i = 0; i < NW; i++) if (sb_we[i]) sb_sel[i] <= sb_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      config_ack <= 1'b0;
      config_err <= 1'b0;
      clb_op     <= CLB_AND;
      clb_reg_en <= 1'b0;
    end else begin
      config_ack <= hit;
      config_err <= hit && wr_bad;
      if (clb_wr) begin
        clb_op     <= clb_op_e'(config_data[1:0]);
        clb_reg_en <= config_data[2];
      end
    end
  end

  connect_box_param #(.NUM_TRACKS(NUM_TRACKS), .CB_SEL_W(CB_SEL_W)) u_cb0 (
    .clk      (clk),
    .reset    (reset),
    .we       (cb0_wr),
    .wsel     (config_data[CB_SEL_W-1:0]),
    .in_side  (in_wire[NUM_TRACKS-1:0]),
    .out_side (out_wire[NUM_TRACKS-1:0]),
    .cb_out   (cb0_out)
  );

  connect_box_param #(.NUM_TRACKS(NUM_TRACKS), .CB_SEL_W(CB_SEL_W)) u_cb1 (
    .clk      (clk),
    .reset    (reset),
    .we       (cb1_wr),
    .wsel     (config_data[CB_SEL_W-1:0]),
    .in_side  (in_wire[2*NUM_TRACKS-1:NUM_TRACKS]),
    .out_side (out_wire[2*NUM_TRACKS-1:NUM_TRACKS]),
    .cb_out   (cb1_out)
  );

  assign pe_comb = clb_eval(clb_op, cb0_out, cb1_out);

  // Stage p1: optional PE output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pe_p1 <= 1'b0;
    else pe_p1 <= pe_comb;
  end

  assign pe_out = clb_reg_en ? pe_p1 : pe_comb;

  always_comb begin
    out_wire = '0;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        if (HAS_SIDE0_OUT || s != 0) begin
          case (sb_sel[s*NUM_TRACKS+t])
            SB_SIDE0: out_wire[s*NUM_TRACKS+t] = in_wire[t];
            SB_SIDE1: out_wire[s*NUM_TRACKS+t] = in_wire[NUM_TRACKS+t];
            SB_SIDE2: out_wire[s*NUM_TRACKS+t] = in_wire[2*NUM_TRACKS+t];
            SB_SIDE3: out_wire[s*NUM_TRACKS+t] = in_wire[3*NUM_TRACKS+t];
            SB_PE:    out_wire[s*NUM_TRACKS+t] = pe_out;
            default:  out_wire[s*NUM_TRACKS+t] = 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_tile_param.sv
// Bench for pe_tile_param (NUM_TRACKS=4): directed steps plus random writes
// checked against a behavioural tile model; a second edge-variant instance.
module tb_pe_tile_param;

  logic        clk;
  logic        reset;
  logic [31:0] config_addr, config_data;
  logic        config_valid;
  logic [15:0] tile_id, tile_id_e;
  logic [15:0] in_wire;
  logic [15:0] out_wire, out_wire_e;
  logic        config_ack, config_err, pe_out;
  logic        ack_e, err_e, pe_out_e_unused;

  int total = 0;
  int bad   = 0;

  int   m_sb [16];
  int   m_cb [2];
  int   m_op;
  logic m_reg;
  logic m_pef;

  pe_tile_param dut (
    .clk(clk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
    .config_valid(config_valid), .tile_id(tile_id), .in_wire(in_wire),
    .out_wire(out_wire), .config_ack(config_ack), .config_err(config_err), .pe_out(pe_out)
  );

  pe_tile_param #(.NUM_TRACKS(4), .HAS_SIDE0_OUT(1'b0)) dut_edge (
    .clk(clk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
    .config_valid(config_valid), .tile_id(tile_id_e), .in_wire(in_wire),
    .out_wire(out_wire_e), .config_ack(ack_e), .config_err(err_e), .pe_out(pe_out_e_unused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_sb[i] = 0;
    m_cb[0] = 0;
    m_cb[1] = 0;
    m_op  = 0;
    m_reg = 1'b0;
    m_pef = 1'b0;
  endfunction

  // Settles the tile's combinational network by repeated evaluation.
  function automatic void model_eval(input logic [15:0] inw, output logic [15:0] ow,
                                     output logic pe, output logic pc);
    logic c0, c1;
    int   s;
    ow = '0;
    pe = 1'b0;
    pc = 1'b0;
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < 16; i++) begin
        s = m_sb[i];
        if (s == 0) ow[i] = 1'b0;
        else if (s <= 4) ow[i] = inw[(s - 1) * 4 + i % 4];
        else ow[i] = pe;
      end
      c0 = (m_cb[0] < 4) ? inw[m_cb[0]] : ow[m_cb[0] - 4];
      c1 = (m_cb[1] < 4) ? inw[4 + m_cb[1]] : ow[4 + m_cb[1] - 4];
      case (m_op)
        0: pc = c0 & c1;
        1: pc = c0 | c1;
        2: pc = c0 ^ c1;
        default: pc = ~c0;
      endcase
      pe = m_reg ? m_pef : pc;
    end
  endfunction

  function automatic void model_write(input logic v, input logic [31:0] a, input logic [31:0] d,
                                      output logic ea, output logic ee);
    int o, s, unit;
    ea = 1'b0;
    ee = 1'b0;
    if (v && a[15:0] == 16'h0003) begin
      ea   = 1'b1;
      unit = int'(a[31:16]);
      if (unit == 7) begin
        o = int'(d[7:0]);
        s = int'(d[10:8]);
        if (o >= 16 || s > 5 || (s >= 1 && s <= 4 && s - 1 == o / 4)) ee = 1'b1;
        else m_sb[o] = s;
      end else if (unit == 6 || unit == 5) begin
        m_cb[6 - unit] = int'(d[2:0]);
      end else if (unit == 4) begin
        m_op  = int'(d[1:0]);
        m_reg = d[2];
      end else begin
        ee = 1'b1;
      end
    end
  endfunction

  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [15:0] inw);
    logic [15:0] ow;
    logic pe, pc, ea, ee;
    config_valid = v;
    config_addr  = a;
    config_data  = d;
    in_wire      = inw;
    #1;
    model_eval(inw, ow, pe, pc);
    check("out_wire", {16'h0, out_wire}, {16'h0, ow});
    check("pe_out", {31'h0, pe_out}, {31'h0, pe});
    model_write(v, a, d, ea, ee);
    m_pef = pc;
    @(posedge clk);
    #1;
    check("ack", {31'h0, config_ack}, {31'h0, ea});
    check("err", {31'h0, config_err}, {31'h0, ee});
    config_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    config_valid = 1'b0;
    config_addr  = '0;
    config_data  = '0;
    tile_id      = 16'h0003;
    tile_id_e    = 16'h0005;
    in_wire      = '0;
    model_reset();
    #2;
    check("rst_out_wire", {16'h0, out_wire}, 32'h0);
    check("rst_ack", {31'h0, config_ack}, 32'h0);
    check("rst_err", {31'h0, config_err}, 32'h0);
    in_wire = 16'h0011;
    #1;
    check("rst_pe_and", {31'h0, pe_out}, 32'h1);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    in_wire = '0;

    // CB0 select track 2 of side 0
    cycle(1'b1, 32'h0006_0003, 32'h2, 16'h0000);
    check("cb0_ack", {31'h0, config_ack}, 32'h1);
    in_wire = 16'h0014;
    #1;
    check("cb0_route", {31'h0, pe_out}, 32'h1);
    cycle(1'b0, 32'h0, 32'h0, 16'h0014);
    check("cb0_ack_once", {31'h0, config_ack}, 32'h0);

    // SB o=5 from side 0, then rejected own-side select
    cycle(1'b1, 32'h0007_0003, 32'h0000_0105, 16'h0002);
    in_wire = 16'h0002;
    #1;
    check("sb_out5", {31'h0, out_wire[5]}, 32'h1);
    cycle(1'b1, 32'h0007_0003, 32'h0000_0205, 16'h0002);
    check("sb_own_ack", {31'h0, config_ack}, 32'h1);
    check("sb_own_err", {31'h0, config_err}, 32'h1);
    check("sb_own_keep", {31'h0, out_wire[5]}, 32'h1);

    // CLB XOR registered, then combinational
    cycle(1'b1, 32'h0006_0003, 32'h0, 16'h0000);
    cycle(1'b1, 32'h0004_0003, 32'h6, 16'h0000);
    cycle(1'b0, 32'h0, 32'h0, 16'h0001);
    check("clb_reg", {31'h0, pe_out}, 32'h1);
    cycle(1'b1, 32'h0004_0003, 32'h2, 16'h0001);
    check("clb_comb", {31'h0, pe_out}, 32'h1);
    in_wire = 16'h0000;
    #1;
    check("clb_comb_follow", {31'h0, pe_out}, 32'h0);

    // Foreign tile id, then back-to-back hits
    cycle(1'b1, 32'h0007_0004, 32'h0000_0105, 16'h0000);
    check("miss_ack", {31'h0, config_ack}, 32'h0);
    cycle(1'b1, 32'h0006_0003, 32'h1, 16'h0000);
    check("b2b_ack1", {31'h0, config_ack}, 32'h1);
    cycle(1'b1, 32'h0005_0003, 32'h2, 16'h0000);
    check("b2b_ack2", {31'h0, config_ack}, 32'h1);
    cycle(1'b0, 32'h0, 32'h0, 16'h0000);
    check("b2b_ack_end", {31'h0, config_ack}, 32'h0);

    // Random writes; SB select 5 is remapped to 6 to keep the network acyclic
    for (int n = 0; n < 400; n++) begin
      int units [6];
      int u, s;
      logic [31:0] a, d;
      logic v;
      units = '{7, 6, 5, 4, 3, 0};
      v = ($urandom_range(0, 3) != 0);
      u = units[$urandom_range(0, 5)];
      a = {u[15:0], ($urandom_range(0, 7) == 0) ? 16'h0004 : 16'h0003};
      d = $urandom;
      if (u == 7) begin
        s = $urandom_range(0, 7);
        if (s == 5) s = 6;
        d[10:8] = s[2:0];
        d[7:0]  = 8'($urandom_range(0, 17));
      end
      cycle(v, a, d, 16'($urandom));
    end

    // PE driven onto track output 8 with OR, combinational
    cycle(1'b1, 32'h0006_0003, 32'h0, 16'h0000);
    cycle(1'b1, 32'h0005_0003, 32'h0, 16'h0000);
    cycle(1'b1, 32'h0004_0003, 32'h1, 16'h0000);
    cycle(1'b1, 32'h0007_0003, 32'h0000_0508, 16'h0000);
    cycle(1'b0, 32'h0, 32'h0, 16'h0001);
    in_wire = 16'h0010;
    #1;
    check("pe_route", {31'h0, out_wire[8]}, 32'h1);

    // Edge variant rejects side-0 outputs
    cycle(1'b1, 32'h0007_0005, 32'h0000_0200, 16'h0001);
    check("edge_o0_ack", {31'h0, ack_e}, 32'h1);
    check("edge_o0_err", {31'h0, err_e}, 32'h1);
    check("edge_side0", {28'h0, out_wire_e[3:0]}, 32'h0);
    cycle(1'b1, 32'h0007_0005, 32'h0000_0104, 16'h0001);
    check("edge_o4_err", {31'h0, err_e}, 32'h0);
    in_wire = 16'h0001;
    #1;
    check("edge_o4_route", {31'h0, out_wire_e[4]}, 32'h1);

    // Asynchronous reset with routes active and ack high
    cycle(1'b1, 32'h0007_0003, 32'h0000_0105, 16'h0013);
    in_wire = 16'h0013;
    #1;
    check("pre_rst_out5", {31'h0, out_wire[5]}, 32'h1);
    reset = 1'b1;
    #1;
    check("arst_out_wire", {16'h0, out_wire}, 32'h0);
    check("arst_ack", {31'h0, config_ack}, 32'h0);
    check("arst_err", {31'h0, config_err}, 32'h0);
    check("arst_pe", {31'h0, pe_out}, 32'h1);
    model_reset();
    config_valid = 1'b1;
    config_addr  = 32'h0007_0003;
    config_data  = 32'h0000_0105;
    @(posedge clk);
    #1;
    check("rst_write_ack", {31'h0, config_ack}, 32'h0);
    check("rst_write_out", {16'h0, out_wire}, 32'h0);
    reset = 1'b0;
    cycle(1'b1, 32'h0007_0003, 32'h0000_0105, 16'h0013);
    cycle(1'b0, 32'h0, 32'h0, 16'h0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
